// File: rtl/touch_int_ctrl_pkg.sv
// Shared definitions for the touch panel reset/INT controller: FSM encoding,
// register map, CTRL bit positions and the per-state pin drive table.
package touch_int_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_RST_LOW    = 3'd1,
        S_ADDR_SETUP = 3'd2,
        S_ADDR_HOLD  = 3'd3,
        S_INT_LOW    = 3'd4,
        S_RUN        = 3'd5
    } state_e;

    localparam logic [1:0] REG_CTRL    = 2'd0;
    localparam logic [1:0] REG_STATUS  = 2'd1;
    localparam logic [1:0] REG_PENDING = 2'd2;
    localparam logic [1:0] REG_EVT_CNT = 2'd3;

    localparam int CTRL_START    = 0;
    localparam int CTRL_ADDR_SEL = 1;
    localparam int CTRL_IRQ_EN   = 2;
    localparam int CTRL_EDGE_SEL = 3;
    localparam int CTRL_STOP     = 4;

    localparam int STAT_BUSY  = 3;
    localparam int STAT_LEVEL = 4;

    // After the controller releases INT the synchronizer still holds the
    // driven value; the debounced level tracks the pin this long before
    // edge detection is trusted.
    localparam logic [1:0] SETTLE_CYC = 2'd3;

    typedef struct packed {
        logic rst_n;
        logic oe;
        logic lvl;
    } pin_drive_t;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    function automatic state_e next_timed(input state_e s);
        case (s)
            S_RST_LOW:    return S_ADDR_SETUP;
            S_ADDR_SETUP: return S_ADDR_HOLD;
            S_ADDR_HOLD:  return S_INT_LOW;
            S_INT_LOW:    return S_RUN;
            default:      return S_IDLE;
        endcase
    endfunction

    function automatic pin_drive_t pin_drive(input state_e s, input logic addr_sel);
        pin_drive_t d;
        d = '{rst_n: 1'b1, oe: 1'b0, lvl: 1'b0};
        case (s)
            S_RST_LOW:    d = '{rst_n: 1'b0, oe: 1'b1, lvl: 1'b0};
            S_ADDR_SETUP: d = '{rst_n: 1'b0, oe: 1'b1, lvl: addr_sel};
            S_ADDR_HOLD:  d = '{rst_n: 1'b1, oe: 1'b1, lvl: addr_sel};
            S_INT_LOW:    d = '{rst_n: 1'b1, oe: 1'b1, lvl: 1'b0};
            default:      d = '{rst_n: 1'b1, oe: 1'b0, lvl: 1'b0};
        endcase
        return d;
    endfunction

endpackage

// File: rtl/touch_int_debounce.sv
// Two-flop synchronizer and debounce filter for the touch INT pin.
// Emits single-cycle rise/fall strobes when the filtered level changes.
module touch_int_debounce
    import touch_int_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYC = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic pin,
    input  logic hold,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam int unsigned CW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);

    logic [1:0]    sync_q;
    logic          sample;
    logic [CW-1:0] cnt;
    logic [1:0]    settle;
    logic          accept;

    assign sample = sync_q[1];
    assign accept = !hold && (settle == 2'd0) && (sample != level) && (cnt == CNT_LAST);
    assign rise   = accept & sample;
    assign fall   = accept & ~sample;

    // NOTE: every register here uses <= so all flops update from the same
    // pre-edge values; a blocking = would let sync_q[1] see this cycle's pin.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= 2'b11;
            level  <= 1'b1;
            cnt    <= '0;
            settle <= 2'd0;
        end else begin
            sync_q <= {sync_q[0], pin};
            if (hold) begin
                settle <= SETTLE_CYC;
                level  <= sample;
                cnt    <= '0;
            end else if (settle != 2'd0) begin
                settle <= settle - 2'd1;
                level  <= sample;
                cnt    <= '0;
            end else if (accept) begin
                level <= sample;
                cnt   <= '0;
            end else if (sample != level) begin
                cnt <= cnt + 1'b1;
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/touch_int_ctrl.sv
// Touch panel reset/INT controller: runs the power-up address-select sequence,
// then raises a maskable interrupt on debounced INT edges. Avalon-MM slave.
module touch_int_ctrl
    import touch_int_ctrl_pkg::*;
#(
    parameter int unsigned RST_LOW_CYC    = 500000,
    parameter int unsigned ADDR_SETUP_CYC = 5000,
    parameter int unsigned ADDR_HOLD_CYC  = 250000,
    parameter int unsigned INT_LOW_CYC    = 2500000,
    parameter int unsigned DEBOUNCE_CYC   = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        irq,
    output logic        touch_rst_n,
    inout  wire         touch_int
);

    localparam int unsigned MAX_CYC = max_u(max_u(RST_LOW_CYC, ADDR_SETUP_CYC),
                                            max_u(ADDR_HOLD_CYC, INT_LOW_CYC));
    localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    function automatic logic [CNT_W-1:0] load_val(input state_e s);
        case (s)
            S_RST_LOW:    return CNT_W'(RST_LOW_CYC - 1);
            S_ADDR_SETUP: return CNT_W'(ADDR_SETUP_CYC - 1);
            S_ADDR_HOLD:  return CNT_W'(ADDR_HOLD_CYC - 1);
            S_INT_LOW:    return CNT_W'(INT_LOW_CYC - 1);
            default:      return '0;
        endcase
    endfunction

    state_e           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    pin_drive_t       drv;

    logic        addr_sel, irq_en, edge_sel;
    logic        pending;
    logic [15:0] evt_cnt;
    logic [31:0] rd_mux;

    logic wr, ctrl_wr, stop_req, start_ok, pend_clr, addr_sel_nxt;
    logic busy, timed;
    logic db_level, db_rise, db_fall, edge_evt;
    logic unused_wdata;

    assign wr       = chipselect & ~write_n;
    assign ctrl_wr  = wr && (address == REG_CTRL);
    assign pend_clr = wr && (address == REG_PENDING) && writedata[0];
    assign stop_req = ctrl_wr && writedata[CTRL_STOP];
    assign busy     = (state != S_IDLE) && (state != S_RUN);
    assign timed    = busy;
    // Stop wins over start in the same write; start is ignored mid-sequence.
    assign start_ok = ctrl_wr && writedata[CTRL_START] && !writedata[CTRL_STOP] && !busy;
    assign addr_sel_nxt = ctrl_wr ? writedata[CTRL_ADDR_SEL] : addr_sel;
    assign unused_wdata = ^writedata[31:5];

    assign touch_rst_n = drv.rst_n;
    assign touch_int   = drv.oe ? drv.lvl : 1'bz;

    touch_int_debounce #(
        .DEBOUNCE_CYC(DEBOUNCE_CYC)
    ) u_debounce (
        .clk  (clk),
        .reset(reset),
        .pin  (touch_int),
        .hold (state != S_RUN),
        .level(db_level),
        .rise (db_rise),
        .fall (db_fall)
    );

    assign edge_evt = (state == S_RUN) && (edge_sel ? db_rise : db_fall);

    // NOTE: outputs take a default before any branch so no path through this
    // block leaves a variable unassigned, which would infer a latch.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (stop_req) begin
            state_nxt = S_IDLE;
            cnt_nxt   = '0;
        end else if (start_ok) begin
            state_nxt = S_RST_LOW;
            cnt_nxt   = load_val(S_RST_LOW);
        end else if (timed) begin
            if (cnt == '0) begin
                state_nxt = next_timed(state);
                cnt_nxt   = load_val(next_timed(state));
            end else begin
                cnt_nxt = cnt - 1'b1;
            end
        end
    end

    always_comb begin
        rd_mux = '0;
        case (address)
            REG_CTRL: begin
                rd_mux[CTRL_ADDR_SEL] = addr_sel;
                rd_mux[CTRL_IRQ_EN]   = irq_en;
                rd_mux[CTRL_EDGE_SEL] = edge_sel;
            end
            REG_STATUS: begin
                rd_mux[2:0]        = state;
                rd_mux[STAT_BUSY]  = busy;
                rd_mux[STAT_LEVEL] = db_level;
            end
            REG_PENDING: rd_mux[0]    = pending;
            default:     rd_mux[15:0] = evt_cnt;
        endcase
    end

    // Pin drive is registered from the next state so pins change together
    // with the state register, never a cycle behind it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            cnt      <= '0;
            drv      <= pin_drive(S_IDLE, 1'b0);
            addr_sel <= 1'b0;
            irq_en   <= 1'b0;
            edge_sel <= 1'b0;
            pending  <= 1'b0;
            evt_cnt  <= '0;
            irq      <= 1'b0;
            readdata <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            drv   <= pin_drive(state_nxt, addr_sel_nxt);
            if (ctrl_wr) begin
                addr_sel <= writedata[CTRL_ADDR_SEL];
                irq_en   <= writedata[CTRL_IRQ_EN];
                edge_sel <= writedata[CTRL_EDGE_SEL];
            end
            // A new edge beats a simultaneous clear so no event is lost.
            pending <= edge_evt | (pending & ~pend_clr);
            if (start_ok) begin
                evt_cnt <= '0;
            end else if (edge_evt) begin
                evt_cnt <= evt_cnt + 16'd1;
            end
            irq      <= pending & irq_en;
            readdata <= rd_mux;
        end
    end

endmodule
